intpol2_iq_flow_ctrl: RTL and testbench
=======================================

// Module: intpol2_iq_flow_ctrl
// PURPOSE
//  Sequencer for the 2nd-order I/Q interpolator datapath. Pops the I and Q input
//  FIFOs in lockstep, primes the 3-sample window, and steps the fractional phase mu.
//  Issues one output strobe per interpolated sample, stalls on downstream almost-full
//  or input empty, and reports busy/done/stop status to the AIP interface.
// PARAMETERS
//  FRAC_W  31  fraction bits of mu and step (Q0.FRAC_W phase)
//  CNT_W   16  width of output-sample length counter
// PORTS
//  clk           in   1         system clock; the only clock in the block
//  rst           in   1         synchronous reset, active-high
//  start_i       in   1         1-cycle start pulse from AIP interface
//  bypass_i      in   1         sampled at start; 1 = pass samples straight through
//  step_i        in   FRAC_W+1  phase step Q1.FRAC_W, legal 1..2^FRAC_W; sampled at start
//  out_len_i     in   CNT_W     number of output samples to produce; sampled at start
//  empty_I_i     in   1         I input FIFO empty
//  empty_Q_i     in   1         Q input FIFO empty
//  afull_i       in   1         downstream FIFO almost-full (I OR Q)
//  rd_en_o       out  1         pop both input FIFOs (1-cycle read latency)
//  shift_o       out  1         core shifts FIFO data into sample window
//  wr_en_o       out  1         core computes/writes one output at mu_o
//  mu_o          out  FRAC_W    current fractional phase for the core
//  busy_o        out  1         run in progress
//  done_o        out  1         1-cycle pulse when out_len outputs issued
//  stop_empty_o  out  1         1 while waiting on empty input
//  stop_afull_o  out  1         1 while stalled by afull_i
// BEHAVIOUR
//  - Reset: all outputs 0, mu=0, counters 0, state IDLE. Reset mid-run aborts at
//    the next edge, with no done pulse. The core window is not cleared.
//  - empty = empty_I_i | empty_Q_i. rd_en_o is only asserted when empty=0.
//  - shift_o = rd_en_o delayed 1 cycle, for all states.
//  - IDLE: start_i latches step, out_len and bypass, then goes to PRIME (bypass=0) or
//    PASS (bypass=1). start_i with step_i==0 or out_len_i==0 sets no busy; out_len==0
//    instead pulses done_o on the next cycle. start_i outside IDLE is ignored.
//  - PRIME: rd_en_o=!empty until 3 pops are issued. After the 3rd shift_o, go to RUN
//    with win_valid=1 and mu=0.
//  - RUN: wr_en_o = win_valid & !afull_i. On each wr_en_o:
//      mu_o = mu; sum = mu + step (FRAC_W+1 bits); mu <= sum[FRAC_W-1:0]; cnt++.
//      If sum[FRAC_W]=1, a new sample is needed: set win_valid=0 and need_pop=1.
//  - Pop rules:
//      need_pop & !empty -> rd_en_o=1 that cycle, then clear need_pop.
//      shift_o cycle     -> win_valid=1 at its end.
//    Minimum bubble per consumed sample is 1 cycle. With step=2^FRAC_W, throughput is
//    1 output per 2 cycles.
//  - need_pop & empty -> stop_empty_o=1, no rd_en_o, and wait; resumes as soon as !empty.
//  - afull_i=1 -> stop_afull_o=1, wr_en_o=0 and mu/cnt hold. A pending pop still
//    proceeds, because pops do not write downstream.
//  - afull_i and an empty wait at the same time: both stop flags are 1.
//  - cnt==out_len after a wr_en_o -> DONE.
//  - PASS (bypass): rd_en_o = !empty & !afull_i, and wr_en_o = shift_o with mu_o=0.
//    cnt counts wr_en_o. stop flags behave as in RUN, with empty checked every cycle.
//  - DONE: done_o=1 for 1 cycle, busy_o=0 next cycle, then IDLE. Any pending pop is
//    dropped. Inputs left in the FIFO stay there.
//  - busy_o=1 in PRIME/RUN/PASS, and 0 in IDLE/DONE.
//  - cnt wraps never: out_len max 2^CNT_W-1.
// TESTING
//  1. step=2^30 (0.5), out_len=8, FIFOs full, afull=0 -> 3 prime pops.
//     Expect 8 wr_en_o with mu_o 0,.5,0,.5,...; 3 further pops; one done_o; busy low after.
//  2. step=2^31 (1.0), out_len=4 -> mu_o always 0, one pop per output, wr_en every 2nd
//     cycle, done_o after 4th wr_en.
//  3. In RUN, hold afull_i=1 for 5 cycles -> wr_en_o=0, stop_afull_o=1, mu and cnt
//     frozen; output resumes on the cycle afull drops.
//  4. empty_Q_i=1 when a pop is needed -> stop_empty_o=1, no rd_en_o. Deassert it:
//     rd_en_o next cycle, shift_o, then wr_en_o, with no lost or duplicated outputs.
//  5. bypass=1, out_len=6 -> no priming, 6 pops, wr_en_o=shift_o, mu_o=0, done_o.
//  6. Assert rst in RUN -> all outputs 0 next edge, no done_o. start_i during busy is
//     ignored. out_len=0 gives done_o only. step=0 gives no busy and no done.

Source files
------------

// File: rtl/intpol2_iq_flow_ctrl.sv
// Flow controller for the 2nd-order I/Q interpolator: primes the 3-sample window,
// steps the fractional phase mu, and paces FIFO pops against output writes.
module intpol2_iq_flow_ctrl #(
    parameter int FRAC_W = 31,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              bypass_i,
    input  logic [FRAC_W:0]   step_i,
    input  logic [CNT_W-1:0]  out_len_i,
    input  logic              empty_I_i,
    input  logic              empty_Q_i,
    input  logic              afull_i,
    output logic              rd_en_o,
    output logic              shift_o,
    output logic              wr_en_o,
    output logic [FRAC_W-1:0] mu_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              stop_empty_o,
    output logic              stop_afull_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_PASS,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [FRAC_W:0]     step_q, step_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FRAC_W-1:0]   mu_q, mu_d;
    logic                win_valid_q, win_valid_d;
    logic                need_pop_q, need_pop_d;
    logic [1:0]          pop_cnt_q, pop_cnt_d;
    logic                shift_q, shift_d;

    logic                empty;
    logic [FRAC_W:0]     sum;
    logic [CNT_W-1:0]    cnt_inc;
    logic                last;
    logic                need_now;
    logic                need_any;
    logic                pass_pending;

    assign empty   = empty_I_i | empty_Q_i;
    assign sum     = {1'b0, mu_q} + step_q;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign last    = (cnt_inc == len_q);
    // In bypass, pops already in flight (shift_q) count toward the length.
    assign pass_pending = ({1'b0, cnt_q} + {{CNT_W{1'b0}}, shift_q}) < {1'b0, len_q};
    assign shift_o = shift_q;

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        mu_d         = mu_q;
        win_valid_d  = win_valid_q;
        need_pop_d   = need_pop_q;
        pop_cnt_d    = pop_cnt_q;
        rd_en_o      = 1'b0;
        wr_en_o      = 1'b0;
        mu_o         = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        stop_empty_o = 1'b0;
        stop_afull_o = 1'b0;
        need_now     = 1'b0;
        need_any     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    step_d      = step_i;
                    len_d       = out_len_i;
                    cnt_d       = '0;
                    mu_d        = '0;
                    pop_cnt_d   = '0;
                    win_valid_d = 1'b0;
                    need_pop_d  = 1'b0;
                    if (out_len_i == '0) begin
                        state_d = S_DONE;
                    end else if (step_i != '0) begin
                        state_d = bypass_i ? S_PASS : S_PRIME;
                    end
                end
            end
            S_PRIME: begin
                busy_o = 1'b1;
                // pop_cnt reaches 3 on the cycle the third sample shifts in.
                if (pop_cnt_q == 2'd3) begin
                    state_d     = S_RUN;
                    win_valid_d = 1'b1;
                    mu_d        = '0;
                end else begin
                    rd_en_o      = !empty;
                    stop_empty_o = empty;
                    if (!empty) begin
                        pop_cnt_d = pop_cnt_q + 2'd1;
                    end
                end
            end
            S_RUN: begin
                busy_o       = 1'b1;
                stop_afull_o = afull_i;
                mu_o         = mu_q;
                wr_en_o      = win_valid_q & !afull_i;
                if (shift_q) begin
                    win_valid_d = 1'b1;
                end
                if (wr_en_o) begin
                    mu_d  = sum[FRAC_W-1:0];
                    cnt_d = cnt_inc;
                    if (last) begin
                        state_d = S_DONE;
                    end else if (sum[FRAC_W]) begin
                        win_valid_d = 1'b0;
                        need_now    = 1'b1;
                    end
                end
                // Popping in the same cycle as the write keeps the bubble to one cycle.
                need_any     = need_pop_q | need_now;
                rd_en_o      = need_any & !empty;
                stop_empty_o = need_any & empty;
                need_pop_d   = need_any & empty;
            end
            S_PASS: begin
                busy_o       = 1'b1;
                stop_afull_o = afull_i;
                wr_en_o      = shift_q;
                rd_en_o      = pass_pending & !empty & !afull_i;
                stop_empty_o = pass_pending & empty;
                if (wr_en_o) begin
                    cnt_d = cnt_inc;
                    if (last) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_o      = 1'b1;
                state_d     = S_IDLE;
                need_pop_d  = 1'b0;
                win_valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        shift_d = rd_en_o;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            mu_q        <= '0;
            win_valid_q <= 1'b0;
            need_pop_q  <= 1'b0;
            pop_cnt_q   <= '0;
            shift_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            mu_q        <= mu_d;
            win_valid_q <= win_valid_d;
            need_pop_q  <= need_pop_d;
            pop_cnt_q   <= pop_cnt_d;
            shift_q     <= shift_d;
        end
    end

endmodule

// File: tb/tb_intpol2_iq_flow_ctrl.sv
// Table-driven bench for intpol2_iq_flow_ctrl: each record is one run with stall
// windows and expected totals; probes pin the outputs at chosen cycles.
module tb_intpol2_iq_flow_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, bypass_i;
    logic [31:0] step_i;
    logic [15:0] out_len_i;
    logic        empty_I_i, empty_Q_i, afull_i;
    logic        rd_en_o, shift_o, wr_en_o, busy_o, done_o, stop_empty_o, stop_afull_o;
    logic [30:0] mu_o;

    intpol2_iq_flow_ctrl #(.FRAC_W(31), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .bypass_i(bypass_i),
        .step_i(step_i), .out_len_i(out_len_i), .empty_I_i(empty_I_i),
        .empty_Q_i(empty_Q_i), .afull_i(afull_i), .rd_en_o(rd_en_o),
        .shift_o(shift_o), .wr_en_o(wr_en_o), .mu_o(mu_o), .busy_o(busy_o),
        .done_o(done_o), .stop_empty_o(stop_empty_o), .stop_afull_o(stop_afull_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               byp;
        logic [31:0]      step;
        logic [15:0]      len;
        int               a_lo, a_hi, e_lo, e_hi;
        bit               e_sel_i;
        int               rst_cyc, restart_cyc;
        int               exp_wr, exp_rd, exp_done, exp_busy;
        logic [7:0][30:0] exp_mu;
    } vec_t;

    typedef struct {
        int          rec;
        int          cyc;
        logic [37:0] exp;
    } probe_t;

    vec_t   vecs[15];
    probe_t probes[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    localparam logic [30:0] HALF = 31'h4000_0000;

    function automatic vec_t mkv(bit byp, logic [31:0] st, logic [15:0] ln,
                                 int alo, int ahi, int elo, int ehi, bit esel,
                                 int rc, int sc, int ew, int er, int ed, int eb,
                                 logic [7:0][30:0] mu);
        vec_t v;
        v.byp = byp; v.step = st; v.len = ln;
        v.a_lo = alo; v.a_hi = ahi; v.e_lo = elo; v.e_hi = ehi; v.e_sel_i = esel;
        v.rst_cyc = rc; v.restart_cyc = sc;
        v.exp_wr = ew; v.exp_rd = er; v.exp_done = ed; v.exp_busy = eb;
        v.exp_mu = mu;
        return v;
    endfunction

    // {wr, rd, shift, stop_afull, stop_empty, busy, done, mu}
    function automatic logic [37:0] pk(bit wr, bit rd, bit sh, bit sa, bit se,
                                       bit bz, bit dn, logic [30:0] mu);
        return {wr, rd, sh, sa, se, bz, dn, mu};
    endfunction

    function automatic probe_t mkp(int r, int c, logic [37:0] e);
        probe_t p;
        p.rec = r; p.cyc = c; p.exp = e;
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int r);
        vec_t v;
        int   nwr, nrd, nbusy, done_cyc;
        bit   prev_rd;
        logic [37:0] act;
        v = vecs[r];
        nwr = 0; nrd = 0; nbusy = 0; done_cyc = 0; prev_rd = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1; bypass_i = v.byp; step_i = v.step; out_len_i = v.len;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            rst       = (cyc == v.rst_cyc);
            start_i   = (cyc == v.restart_cyc);
            afull_i   = (v.a_lo != 0) && (cyc >= v.a_lo) && (cyc <= v.a_hi);
            empty_Q_i = !v.e_sel_i && (v.e_lo != 0) && (cyc >= v.e_lo) && (cyc <= v.e_hi);
            empty_I_i =  v.e_sel_i && (v.e_lo != 0) && (cyc >= v.e_lo) && (cyc <= v.e_hi);
            @(negedge clk);
            check($sformatf("r%0d_c%0d_shift", r, cyc), 64'(shift_o), 64'(prev_rd));
            check($sformatf("r%0d_c%0d_rd_when_empty", r, cyc),
                  64'(rd_en_o & (empty_I_i | empty_Q_i)), 64'(0));
            if (wr_en_o) begin
                if (nwr < 8) begin
                    check($sformatf("r%0d_mu%0d", r, nwr), 64'(mu_o), 64'(v.exp_mu[nwr]));
                end
                nwr++;
            end
            if (rd_en_o) nrd++;
            if (busy_o) nbusy++;
            if (done_o && done_cyc == 0) done_cyc = cyc;
            act = pk(wr_en_o, rd_en_o, shift_o, stop_afull_o, stop_empty_o, busy_o, done_o, mu_o);
            foreach (probes[i]) begin
                if (probes[i].rec == r && probes[i].cyc == cyc) begin
                    check($sformatf("r%0d_c%0d_probe", r, cyc), 64'(act), 64'(probes[i].exp));
                end
            end
            prev_rd = rd_en_o && !rst;
            @(posedge clk); #1;
        end
        rst = 1'b0; start_i = 1'b0; afull_i = 1'b0; empty_I_i = 1'b0; empty_Q_i = 1'b0;
        check($sformatf("r%0d_wr_count", r), 64'(nwr), 64'(v.exp_wr));
        check($sformatf("r%0d_rd_count", r), 64'(nrd), 64'(v.exp_rd));
        check($sformatf("r%0d_done_cycle", r), 64'(done_cyc), 64'(v.exp_done));
        check($sformatf("r%0d_busy_cycles", r), 64'(nbusy), 64'(v.exp_busy));
        $display("run %0d: bypass=%0d step=%08h len=%0d -> wr=%0d rd=%0d done@%0d busy=%0d",
                 r, v.byp, v.step, v.len, nwr, nrd, done_cyc, nbusy);
    endtask

    initial begin
        logic [7:0][30:0] mu_alt, mu_zero, mu_q25, mu_q75;
        mu_alt  = {4{HALF, 31'h0}};
        mu_zero = '0;
        mu_q25  = {31'h0, 31'h0, 31'h0, 31'h0, 31'h6000_0000, 31'h4000_0000, 31'h2000_0000, 31'h0};
        mu_q75  = {31'h0, 31'h0, 31'h0, 31'h0, 31'h2000_0000, 31'h4000_0000, 31'h6000_0000, 31'h0};

        //                byp step          len a_lo a_hi e_lo e_hi esel rst rs  wr rd done busy mu
        vecs[0]  = mkv(0, 32'h4000_0000, 8,  0,   0,   0,   0,   0,   0,  0,  8, 6, 16, 15, mu_alt);
        vecs[1]  = mkv(0, 32'h8000_0000, 4,  0,   0,   0,   0,   0,   0,  0,  4, 6, 12, 11, mu_zero);
        vecs[2]  = mkv(0, 32'h2000_0000, 5,  0,   0,   0,   0,   0,   0,  0,  5, 4, 11, 10, mu_q25);
        vecs[3]  = mkv(0, 32'h6000_0000, 4,  0,   0,   0,   0,   0,   0,  0,  4, 5, 11, 10, mu_q75);
        vecs[4]  = mkv(0, 32'h4000_0000, 8,  6,  10,   0,   0,   0,   0,  0,  8, 6, 21, 20, mu_alt);
        vecs[5]  = mkv(0, 32'h8000_0000, 4,  0,   0,   5,   8,   0,   0,  0,  4, 6, 16, 15, mu_zero);
        vecs[6]  = mkv(0, 32'h8000_0000, 4,  6,   7,   5,   8,   0,   0,  0,  4, 6, 16, 15, mu_zero);
        vecs[7]  = mkv(0, 32'h8000_0000, 4,  6,   6,   5,   5,   0,   0,  0,  4, 6, 13, 12, mu_zero);
        vecs[8]  = mkv(1, 32'h4000_0000, 6,  0,   0,   0,   0,   0,   0,  0,  6, 6,  8,  7, mu_zero);
        vecs[9]  = mkv(1, 32'h4000_0000, 6,  0,   0,   3,   4,   1,   0,  0,  6, 6, 10,  9, mu_zero);
        vecs[10] = mkv(0, 32'h4000_0000, 0,  0,   0,   0,   0,   0,   0,  0,  0, 0,  1,  0, mu_zero);
        vecs[11] = mkv(0, 32'h0000_0000, 8,  0,   0,   0,   0,   0,   0,  0,  0, 0,  0,  0, mu_zero);
        vecs[12] = mkv(0, 32'h4000_0000, 8,  0,   0,   0,   0,   0,   6,  0,  2, 4,  0,  6, mu_alt);
        vecs[13] = mkv(0, 32'h4000_0000, 8,  0,   0,   0,   0,   0,   0,  6,  8, 6, 16, 15, mu_alt);
        vecs[14] = mkv(1, 32'h4000_0000, 6,  3,   3,   0,   0,   0,   0,  0,  6, 6,  9,  8, mu_zero);

        //                          wr rd sh sa se bz dn mu
        probes.push_back(mkp(0,  4, pk(0, 0, 1, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(0,  5, pk(1, 0, 0, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(0,  6, pk(1, 1, 0, 0, 0, 1, 0, HALF)));
        probes.push_back(mkp(0,  7, pk(0, 0, 1, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(0, 16, pk(0, 0, 0, 0, 0, 0, 1, 31'h0)));
        probes.push_back(mkp(0, 17, pk(0, 0, 0, 0, 0, 0, 0, 31'h0)));
        probes.push_back(mkp(1,  5, pk(1, 1, 0, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(1,  6, pk(0, 0, 1, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(4,  6, pk(0, 0, 0, 1, 0, 1, 0, HALF)));
        probes.push_back(mkp(4, 10, pk(0, 0, 0, 1, 0, 1, 0, HALF)));
        probes.push_back(mkp(4, 11, pk(1, 1, 0, 0, 0, 1, 0, HALF)));
        probes.push_back(mkp(5,  5, pk(1, 0, 0, 0, 1, 1, 0, 31'h0)));
        probes.push_back(mkp(5,  9, pk(0, 1, 0, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(5, 10, pk(0, 0, 1, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(5, 11, pk(1, 1, 0, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(6,  6, pk(0, 0, 0, 1, 1, 1, 0, 31'h0)));
        probes.push_back(mkp(7,  6, pk(0, 1, 0, 1, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(8,  1, pk(0, 1, 0, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(8,  2, pk(1, 1, 1, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(8,  7, pk(1, 0, 1, 0, 0, 1, 0, 31'h0)));
        probes.push_back(mkp(8,  8, pk(0, 0, 0, 0, 0, 0, 1, 31'h0)));
        probes.push_back(mkp(9,  3, pk(1, 0, 1, 0, 1, 1, 0, 31'h0)));
        probes.push_back(mkp(9,  4, pk(0, 0, 0, 0, 1, 1, 0, 31'h0)));
        probes.push_back(mkp(10, 1, pk(0, 0, 0, 0, 0, 0, 1, 31'h0)));
        probes.push_back(mkp(11, 1, pk(0, 0, 0, 0, 0, 0, 0, 31'h0)));
        probes.push_back(mkp(12, 7, pk(0, 0, 0, 0, 0, 0, 0, 31'h0)));
        probes.push_back(mkp(14, 3, pk(1, 0, 1, 1, 0, 1, 0, 31'h0)));

        rst = 1'b1; start_i = 1'b0; bypass_i = 1'b0; step_i = '0; out_len_i = '0;
        empty_I_i = 1'b0; empty_Q_i = 1'b0; afull_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'(pk(wr_en_o, rd_en_o, shift_o, stop_afull_o, stop_empty_o, busy_o, done_o, mu_o)),
              64'(0));
        @(posedge clk); #1;
        rst = 1'b0; afull_i = 1'b0;

        for (int r = 0; r < 15; r++) begin
            run_vec(r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
